// File: rtl/mem_access_fsm_pkg.sv
// Shared definitions for the load/store access unit: MIPS memory opcodes,
// FSM state encoding and lane-width helpers.
package mem_access_fsm_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of address bits that select a byte lane within one bus word.
    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/mem_access_fsm_lane_align.sv
// Combinational lane logic: byte enables, store-data replication, load-data
// extraction with sign/zero extension, and alignment checks.
module mem_lane_align
    import mem_access_fsm_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LANE_W = lane_bits(DATA_W)
) (
    input  logic [5:0]        op,
    input  logic [LANE_W-1:0] lane,
    input  logic [31:0]       wdata,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [31:0]       rdata_ext,
    output logic              adel,
    output logic              ades
);

    logic [NB-1:0]     be_base;
    logic [LANE_W+2:0] bit_off;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       word_v;

    assign bit_off = {lane, 3'b000};
    // Misaligned lanes never reach the bus, so out-of-range selects are harmless.
    assign byte_v  = data_rdata[bit_off +: 8];
    assign half_v  = data_rdata[bit_off +: 16];
    assign word_v  = data_rdata[bit_off +: 32];

    always_comb begin
        be_base   = '0;
        wdata_rep = {(NB / 4){wdata}};
        rdata_ext = word_v;
        case (op)
            OP_LB, OP_LBU, OP_SB: be_base = NB'(4'h1);
            OP_LH, OP_LHU, OP_SH: be_base = NB'(4'h3);
            OP_LW, OP_SW:         be_base = NB'(4'hf);
            default:              be_base = '0;
        endcase
        case (op)
            OP_SB:   wdata_rep = {NB{wdata[7:0]}};
            OP_SH:   wdata_rep = {(NB / 2){wdata[15:0]}};
            default: wdata_rep = {(NB / 4){wdata}};
        endcase
        case (op)
            OP_LB:   rdata_ext = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  rdata_ext = {24'h0, byte_v};
            OP_LH:   rdata_ext = {{16{half_v[15]}}, half_v};
            OP_LHU:  rdata_ext = {16'h0, half_v};
            default: rdata_ext = word_v;
        endcase
    end

    assign be   = be_base << lane;
    assign adel = (((op == OP_LH) || (op == OP_LHU)) && lane[0]) ||
                  ((op == OP_LW) && (lane[1:0] != 2'b00));
    assign ades = ((op == OP_SH) && lane[0]) ||
                  ((op == OP_SW) && (lane[1:0] != 2'b00));

endmodule

// File: rtl/mem_access_fsm.sv
// MEM-stage load/store unit: drives a split address/data bus handshake,
// stalls the pipeline until the response arrives and drains flushed accesses.
module mem_access_fsm
    import mem_access_fsm_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  ADDR_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LANE_W = lane_bits(DATA_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic [5:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              adel,
    output logic              ades,
    output logic              data_req,
    output logic              data_wr,
    output logic [NB-1:0]     data_be,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_t              state_reg, state_next;
    logic                discard_reg, discard_next;
    logic [5:0]          op_reg;
    logic [LANE_W-1:0]   lane_reg;
    logic [NB-1:0]       be_reg;
    logic                wr_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [31:0]         rdata_reg;

    logic                idle, start, capture, rdata_load;
    logic [5:0]          sel_op;
    logic [LANE_W-1:0]   sel_lane;
    logic [NB-1:0]       be;
    logic [DATA_W-1:0]   wdata_rep;
    logic [31:0]         rdata_ext;

    // While idle the lane logic looks at the live request; afterwards it
    // works on the captured access so the extract uses the issuing op.
    assign idle     = (state_reg == ST_IDLE);
    assign sel_op   = idle ? op : op_reg;
    assign sel_lane = idle ? addr[LANE_W-1:0] : lane_reg;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .op         (sel_op),
        .lane       (sel_lane),
        .wdata      (wdata),
        .data_rdata (data_rdata),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext),
        .adel       (adel),
        .ades       (ades)
    );

    assign start   = req_valid && is_mem(op) && !adel && !ades && !flush;
    assign capture = idle && start;

    always_comb begin
        state_next   = state_reg;
        discard_next = discard_reg;
        rdata_load   = 1'b0;
        stall        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                stall = start;
                if (start) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                stall = !discard_reg || (req_valid && !flush);
                if (data_addr_ok) begin
                    state_next   = ST_DATA;
                    discard_next = flush;
                end else if (flush) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                // A discarding access only holds the pipeline if a new request waits behind it.
                stall = !discard_reg || (req_valid && !flush);
                if (data_data_ok) begin
                    rdata_load   = !discard_reg && !flush && is_load(op_reg);
                    state_next   = (discard_reg || flush) ? ST_IDLE : ST_DONE;
                    discard_next = 1'b0;
                end else if (flush) begin
                    discard_next = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            discard_reg <= 1'b0;
            op_reg      <= '0;
            lane_reg    <= '0;
            be_reg      <= '0;
            wr_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            discard_reg <= discard_next;
            if (capture) begin
                op_reg    <= op;
                lane_reg  <= addr[LANE_W-1:0];
                be_reg    <= be;
                wr_reg    <= is_store(op);
                addr_reg  <= {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                wdata_reg <= wdata_rep;
            end
            if (rdata_load) rdata_reg <= rdata_ext;
        end
    end

    assign data_req   = (state_reg == ST_ADDR);
    assign data_wr    = data_req && wr_reg;
    assign data_be    = data_req ? be_reg : '0;
    assign data_addr  = data_req ? addr_reg : '0;
    assign data_wdata = data_req ? wdata_reg : '0;
    assign rdata      = rdata_reg;

endmodule

// File: doc/mem_access_fsm.md
# mem_access_fsm

Parametrised load/store access unit sitting between the MEM stage of the MIPS pipeline and an SRAM-like data bus with split address/data handshakes. For LB/LBU/LH/LHU/LW/SB/SH/SW it:
- checks alignment and raises AdEL/AdES;
- generates byte enables and replicated write data for DATA_W-bit lanes;
- runs the request through a 4-state FSM, stalling the pipeline until the data phase completes;
- aligns and extends load data.

It also supports flush (exception/eret) mid-transaction, draining outstanding responses without corrupting the next access.

## Interface
Parameters:
- DATA_W, 32, bus data width; 32 or 64 only
- ADDR_W, 32, address width

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage holds a memory instruction
- op  in  6  MIPS primary opcode (shared defines)
- addr  in  ADDR_W  effective address
- wdata  in  32  store source register
- flush  in  1  pipeline flush; abort or discard current access
- stall  out  1  freeze pipeline at/behind MEM
- rdata  out  32  aligned, extended load result
- adel  out  1  load address error (combinational)
- ades  out  1  store address error (combinational)
- data_req  out  1  bus address-phase request
- data_wr  out  1  1 = write
- data_be  out  DATA_W/8  byte enables
- data_addr  out  ADDR_W  address, low log2(DATA_W/8) bits zeroed
- data_wdata  out  DATA_W  lane-replicated store data
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  DATA_W  read data

## Operation
- Lane index L = addr[log2(DATA_W/8)-1:0]. Byte n of data_be corresponds to data_rdata/data_wdata bits [8n+7:8n].
- Byte enables, one-hot or contiguous at L:
  - SB: 1 byte
  - SH: 2 bytes
  - SW: 4 bytes
  - loads: also drive the bytes they read
  - data_wr = 1 for stores only.
- Write data: SB replicates byte[7:0] to all lanes; SH replicates [15:0]; SW replicates [31:0] (DATA_W = 64 gives two copies).
- Load extract: take the byte/half/word at L. LB/LH sign-extend; LBU/LHU zero-extend.
- Address errors:
  - adel = (LH|LHU) & addr[0], or LW & addr[1:0] != 0.
  - ades: same rule for SH/SW.
- Start condition: start = req_valid & memory op & !adel & !ades & !flush. An access that raises adel/ades issues no bus request and does not stall.
- FSM states: IDLE, ADDR, DATA, DONE; a discard flag is held alongside.
  - IDLE → ADDR on start. Register op, L, be, wr, addr, wdata.
  - ADDR: data_req = 1, bus fields driven from registers.
    - On addr_ok → DATA.
    - On flush & !addr_ok → IDLE; the request is withdrawn, which is legal.
    - On flush & addr_ok → DATA with discard = 1.
  - DATA: on data_ok → DONE, or → IDLE if discard | flush; discard clears. If flush arrives without data_ok, discard is set.
  - DONE → IDLE unconditionally.
- rdata register:
  - Loads the extracted value on data_ok when not discarding and the op is a load.
  - Otherwise holds its value.
- stall:
  - 1 in IDLE while start is asserted.
  - 1 in ADDR and DATA when discard = 0.
  - 1 when discarding and req_valid & !flush; the new access waits behind the drain.
  - 0 in DONE.

## Timing
- Reset (async, resetn low): state = IDLE, discard = 0, rdata = 0, data_req = 0, data_wr = 0, data_be = 0, data_addr = 0, data_wdata = 0, stall = 0.
- Cycle 0: start seen in IDLE, stall = 1.
- Cycle 1+: data_req = 1 until addr_ok.
- Cycle after the data_ok cycle: DONE, stall = 0, rdata valid, pipeline advances.
- Minimum latency, with addr_ok and data_ok each asserted in the first cycle they can be: 4 cycles per access (IDLE, ADDR, DATA, DONE).
- data_ok may arrive the cycle after addr_ok at the earliest. Only one transaction is outstanding at a time.
- flush and data_ok in the same DATA cycle: response dropped, rdata unchanged, → IDLE.
- resetn deasserted mid-transaction: FSM returns to IDLE. The bus side is reset in the same domain, so no drain is required.

## Structure
- Shared package/header:
  - opcode constants (LB..SW), already in the common defines;
  - FSM state encoding;
  - lane-width localparam helpers.
- One sub-module, mem_lane_align (combinational):
  - inputs: op, L, wdata, data_rdata;
  - outputs: be, replicated wdata, extended rdata, adel, ades.
- Parametrised on DATA_W.
- The FSM and registers live in mem_access_fsm.

## Test plan
- SW addr 0x1004, wdata 0xDEADBEEF, DATA_W = 64, immediate acks:
  - data_be = 8'hF0, data_wdata = 0xDEADBEEF_DEADBEEF, data_addr = 0x1000;
  - stall high for exactly 3 cycles.
- LB addr 0x...3, DATA_W = 32, data_rdata = 0x80112233 → rdata = 0xFFFFFF80. Same setup with LBU → 0x00000080.
- LH addr 0x...1 → adel = 1, no data_req, stall = 0. SW addr 0x...2 → ades = 1.
- addr_ok held low for 5 cycles → data_req and registered fields stable throughout, stall = 1 throughout.
- flush in DATA before data_ok, then new LW issued next cycle:
  - first data_ok discarded and rdata unchanged;
  - new request starts only after that data_ok.
- resetn pulsed low during ADDR → all outputs 0 immediately, state IDLE, and the next LW completes normally.
